// File: rtl/sys_array_scheduler_if.sv
// Thread-side and array-side signal bundle for sys_array_scheduler.
// Latency: none, wires only. Grants from the scheduler are its only flow control.
// Backpressure: requests are levels that the threads hold until they see a grant.
interface sys_array_scheduler_if #(
    parameter int ADDRWIDTH = 16,
    parameter int MESHUNITS = 4,
    parameter int TILEUNITS = 4,
    parameter int NTHREADS  = 4
);
    localparam int L  = MESHUNITS * TILEUNITS;
    localparam int SW = $clog2(L) + 1;

    // compute lock: A/D read, C write
    logic [NTHREADS-1:0]                 comp_req;
    logic [NTHREADS-1:0][ADDRWIDTH-1:0]  A_addr;
    logic [NTHREADS-1:0][ADDRWIDTH-1:0]  D_addr;
    logic [NTHREADS-1:0][ADDRWIDTH-1:0]  C_addr;
    logic [NTHREADS-1:0]                 comp_grant;
    logic [NTHREADS-1:0]                 comp_done;

    // load lock: B read
    logic [NTHREADS-1:0]                 load_req;
    logic [NTHREADS-1:0][ADDRWIDTH-1:0]  B_addr;
    logic [NTHREADS-1:0]                 load_grant;
    logic [NTHREADS-1:0]                 load_done;

    // per-lane streams towards the tile memories and the array
    logic [MESHUNITS-1:0][ADDRWIDTH-1:0] A_row_read_addrs;
    logic [MESHUNITS-1:0][ADDRWIDTH-1:0] D_col_read_addrs;
    logic [MESHUNITS-1:0]                comp_read_en;
    logic [MESHUNITS-1:0]                ad_valid;
    logic [MESHUNITS-1:0][ADDRWIDTH-1:0] C_col_write_addrs;
    logic [MESHUNITS-1:0]                C_write_en;
    logic [MESHUNITS-1:0][ADDRWIDTH-1:0] B_col_read_addrs;
    logic [MESHUNITS-1:0]                load_read_en;
    logic [MESHUNITS-1:0]                b_valid;
    logic [MESHUNITS-1:0][SW-1:0]        b_shelf_life;
    logic                                b_propagate;

    // thread front-ends
    modport master (
        output comp_req, A_addr, D_addr, C_addr, load_req, B_addr,
        input  comp_grant, comp_done, load_grant, load_done,
        input  A_row_read_addrs, D_col_read_addrs, comp_read_en, ad_valid,
        input  C_col_write_addrs, C_write_en, B_col_read_addrs, load_read_en,
        input  b_valid, b_shelf_life, b_propagate
    );

    // scheduler
    modport slave (
        input  comp_req, A_addr, D_addr, C_addr, load_req, B_addr,
        output comp_grant, comp_done, load_grant, load_done,
        output A_row_read_addrs, D_col_read_addrs, comp_read_en, ad_valid,
        output C_col_write_addrs, C_write_en, B_col_read_addrs, load_read_en,
        output b_valid, b_shelf_life, b_propagate
    );
endinterface

// File: rtl/sys_array_scheduler.sv
// NTHREADS-way compute/load lock arbiter and per-lane address sequencer for the systolic array.
// Latency: grant 1 edge after request; a compute holds MU*(2+TU)+1 cycles and a load MU*(1+TU)+1 cycles.
// Backpressure: none accepted; requests wait as levels until granted. SYS_SCHED_RR_EN selects round-robin arbitration.
module sys_array_scheduler #(
    parameter int ADDRWIDTH = 16,
    parameter int MESHUNITS = 4,
    parameter int TILEUNITS = 4,
    parameter int NTHREADS  = 4
) (
    input logic                  clock,
    input logic                  reset,
    sys_array_scheduler_if.slave bus
);
    localparam int L    = MESHUNITS * TILEUNITS;
    localparam int CEND = MESHUNITS * (2 + TILEUNITS);
    localparam int LEND = MESHUNITS * (1 + TILEUNITS);
    localparam int CW   = $clog2(CEND + 1);
    localparam int SW   = $clog2(L) + 1;
    localparam int PW   = $clog2(NTHREADS);

    // Lock ownership and stream counters
    logic [NTHREADS-1:0]  comp_owner, load_owner;
    logic [CW-1:0]        comp_k, load_l;
    logic [ADDRWIDTH-1:0] a_base, d_base, c_base, b_base;
    logic                 bank;

    logic comp_busy, load_busy, comp_fin, load_fin;
    int   kk, ll;

    assign comp_busy = |comp_owner;
    assign load_busy = |load_owner;
    assign comp_fin  = comp_busy && (comp_k == CW'(CEND));
    assign load_fin  = load_busy && (load_l == CW'(LEND));
    assign kk        = int'(comp_k);
    assign ll        = int'(load_l);

    // First requester found scanning upwards from start, wrapping around.
    function automatic logic [NTHREADS-1:0] arb(input logic [NTHREADS-1:0] req,
                                                 input logic [PW-1:0]       start);
        logic [NTHREADS-1:0] g;
        logic                found;
        int                  idx;
        g     = '0;
        found = 1'b0;
        for (int o = 0; o < NTHREADS; o++) begin
            idx = (int'(start) + o) % NTHREADS;
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    logic [PW-1:0] comp_ptr, load_ptr;

`ifdef SYS_SCHED_RR_EN
    // Search start for the next round: the thread after the grantee.
    function automatic logic [PW-1:0] next_ptr(input logic [NTHREADS-1:0] oh);
        logic [PW-1:0] p;
        p = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            if (oh[t]) p = (t == NTHREADS - 1) ? '0 : PW'(t + 1);
        end
        return p;
    endfunction
`endif

    logic [NTHREADS-1:0] load_hold, comp_elig, comp_pick, comp_hold, load_elig, load_pick;

    // Compute picks first; load then skips whichever thread owns compute after this edge.
    always_comb begin
        load_hold = (load_busy && !load_fin) ? load_owner : '0;
        comp_elig = bus.comp_req & ~load_hold;
        comp_pick = comp_busy ? '0 : arb(comp_elig, comp_ptr);
        comp_hold = comp_busy ? (comp_fin ? '0 : comp_owner) : comp_pick;
        load_elig = bus.load_req & ~comp_hold;
        load_pick = load_busy ? '0 : arb(load_elig, load_ptr);
    end

    logic [ADDRWIDTH-1:0] sel_a, sel_d, sel_c, sel_b;

    // Base addresses of the thread being granted this edge.
    always_comb begin
        sel_a = '0;
        sel_d = '0;
        sel_c = '0;
        sel_b = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            sel_a = sel_a | (bus.A_addr[t] & {ADDRWIDTH{comp_pick[t]}});
            sel_d = sel_d | (bus.D_addr[t] & {ADDRWIDTH{comp_pick[t]}});
            sel_c = sel_c | (bus.C_addr[t] & {ADDRWIDTH{comp_pick[t]}});
            sel_b = sel_b | (bus.B_addr[t] & {ADDRWIDTH{load_pick[t]}});
        end
    end

    // Compute lock: grant, count k up to its end value, release on done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            comp_owner <= '0;
            comp_k     <= '0;
            a_base     <= '0;
            d_base     <= '0;
            c_base     <= '0;
        end else if (comp_busy) begin
            if (comp_fin) begin
                comp_owner <= '0;
                comp_k     <= '0;
            end else begin
                comp_k <= comp_k + CW'(1);
            end
        end else if (|comp_pick) begin
            comp_owner <= comp_pick;
            comp_k     <= '0;
            a_base     <= sel_a;
            d_base     <= sel_d;
            c_base     <= sel_c;
        end
    end

    // Load lock: same life cycle; each completed load flips the B bank.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_owner <= '0;
            load_l     <= '0;
            b_base     <= '0;
            bank       <= 1'b0;
        end else if (load_busy) begin
            if (load_fin) begin
                load_owner <= '0;
                load_l     <= '0;
                bank       <= ~bank;
            end else begin
                load_l <= load_l + CW'(1);
            end
        end else if (|load_pick) begin
            load_owner <= load_pick;
            load_l     <= '0;
            b_base     <= sel_b;
        end
    end

`ifdef SYS_SCHED_RR_EN
    // Independent round-robin pointers, advanced only when their lock is granted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            comp_ptr <= '0;
            load_ptr <= '0;
        end else begin
            if (|comp_pick) comp_ptr <= next_ptr(comp_pick);
            if (|load_pick) load_ptr <= next_ptr(load_pick);
        end
    end
`else
    assign comp_ptr = '0;
    assign load_ptr = '0;
`endif

    assign bus.comp_grant = comp_owner;
    assign bus.load_grant = load_owner;
    assign bus.comp_done  = comp_fin ? comp_owner : '0;
    assign bus.load_done  = load_fin ? load_owner : '0;

    // Compute streams: lane i is skewed by i cycles; C writes trail the reads by MU+1.
    always_comb begin
        bus.comp_read_en      = '0;
        bus.ad_valid          = '0;
        bus.C_write_en        = '0;
        bus.A_row_read_addrs  = '0;
        bus.D_col_read_addrs  = '0;
        bus.C_col_write_addrs = '0;
        for (int i = 0; i < MESHUNITS; i++) begin
            if (comp_busy && kk >= i && kk < L + i) begin
                bus.comp_read_en[i]     = 1'b1;
                bus.A_row_read_addrs[i] = a_base + ADDRWIDTH'((kk - i) * L + i * TILEUNITS);
                bus.D_col_read_addrs[i] = d_base + ADDRWIDTH'((kk - i) * L + i * TILEUNITS);
            end
            // the read issued one cycle earlier is now presented to the array
            if (comp_busy && kk >= i + 1 && kk < L + i + 1) begin
                bus.ad_valid[i] = 1'b1;
            end
            if (comp_busy && kk >= MESHUNITS + 1 + i && kk < MESHUNITS + 1 + i + L) begin
                bus.C_write_en[i]        = 1'b1;
                bus.C_col_write_addrs[i] = c_base
                    + ADDRWIDTH'((kk - MESHUNITS - 1 - i) * L + i * TILEUNITS);
            end
        end
    end

    logic any_bv;

    // Load streams: B reads, their one-cycle-late valid, remaining shelf life and bank select.
    always_comb begin
        bus.load_read_en     = '0;
        bus.B_col_read_addrs = '0;
        bus.b_valid          = '0;
        bus.b_shelf_life     = '0;
        any_bv               = 1'b0;
        for (int i = 0; i < MESHUNITS; i++) begin
            if (load_busy && ll >= i && ll < L + i) begin
                bus.load_read_en[i]     = 1'b1;
                bus.B_col_read_addrs[i] = b_base + ADDRWIDTH'((ll - i) * L + i * TILEUNITS);
            end
            if (load_busy && ll >= i + 1 && ll < L + i + 1) begin
                bus.b_valid[i]      = 1'b1;
                bus.b_shelf_life[i] = SW'(L - (ll - 1 - i));
                any_bv              = 1'b1;
            end
        end
        bus.b_propagate = any_bv & bank;
    end
endmodule

// File: tb/tb_sys_array_scheduler.sv
// Directed bench for sys_array_scheduler at MU=2, TU=2 (L=4), four threads.
// Latency: inputs change 1ns after a rising edge, outputs are sampled on the falling edge.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_sys_array_scheduler;
    localparam int AW = 16;
    localparam int MU = 2;
    localparam int TU = 2;
    localparam int NT = 4;

    logic clock;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    sys_array_scheduler_if #(.ADDRWIDTH(AW), .MESHUNITS(MU), .TILEUNITS(TU), .NTHREADS(NT)) bus ();

    sys_array_scheduler #(.ADDRWIDTH(AW), .MESHUNITS(MU), .TILEUNITS(TU), .NTHREADS(NT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // one compute cycle: input comp_req, then the expected outputs for that k
    typedef struct {
        logic [3:0]  req;
        logic [1:0]  en;
        logic [15:0] a0, a1, d0;
        logic [1:0]  adv, cwe;
        logic [15:0] c0, c1;
        logic [3:0]  done, grant;
    } cvec_t;

    cvec_t cv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((bus.comp_grant != 0 || bus.load_grant != 0) && t < 60) begin
            @(negedge clock);
            t++;
        end
        chk("idle", 32'({bus.comp_grant, bus.load_grant}), 32'(0));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g;
        logic       v0, v1;
        int         t;

        //        req      en     a0       a1       d0       adv    cwe    c0       c1       done     grant
        cv[0] = '{4'b0100, 2'b01, 16'h100, 16'h000, 16'h200, 2'b00, 2'b00, 16'h000, 16'h000, 4'b0000, 4'b0100};
        cv[1] = '{4'b0100, 2'b11, 16'h104, 16'h102, 16'h204, 2'b01, 2'b00, 16'h000, 16'h000, 4'b0000, 4'b0100};
        cv[2] = '{4'b0000, 2'b11, 16'h108, 16'h106, 16'h208, 2'b11, 2'b00, 16'h000, 16'h000, 4'b0000, 4'b0100};
        cv[3] = '{4'b0000, 2'b11, 16'h10C, 16'h10A, 16'h20C, 2'b11, 2'b01, 16'h300, 16'h000, 4'b0000, 4'b0100};
        cv[4] = '{4'b0000, 2'b10, 16'h000, 16'h10E, 16'h000, 2'b11, 2'b11, 16'h304, 16'h302, 4'b0000, 4'b0100};
        cv[5] = '{4'b0000, 2'b00, 16'h000, 16'h000, 16'h000, 2'b10, 2'b11, 16'h308, 16'h306, 4'b0000, 4'b0100};
        cv[6] = '{4'b0000, 2'b00, 16'h000, 16'h000, 16'h000, 2'b00, 2'b11, 16'h30C, 16'h30A, 4'b0000, 4'b0100};
        cv[7] = '{4'b0000, 2'b00, 16'h000, 16'h000, 16'h000, 2'b00, 2'b10, 16'h000, 16'h30E, 4'b0000, 4'b0100};
        cv[8] = '{4'b0000, 2'b00, 16'h000, 16'h000, 16'h000, 2'b00, 2'b00, 16'h000, 16'h000, 4'b0100, 4'b0100};
        cv[9] = '{4'b0000, 2'b00, 16'h000, 16'h000, 16'h000, 2'b00, 2'b00, 16'h000, 16'h000, 4'b0000, 4'b0000};

        reset        = 1'b0;
        bus.comp_req = '0;
        bus.load_req = '0;
        for (int i = 0; i < NT; i++) begin
            bus.A_addr[i] = 16'(16'h1000 * (i + 1));
            bus.D_addr[i] = 16'(16'h1100 * (i + 1));
            bus.C_addr[i] = 16'(16'h1200 * (i + 1));
            bus.B_addr[i] = 16'(16'h1300 * (i + 1));
        end

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_comp_grant", 32'(bus.comp_grant), 32'(0));
        chk("rst_load_grant", 32'(bus.load_grant), 32'(0));
        chk("rst_read_en", 32'({bus.comp_read_en, bus.load_read_en, bus.C_write_en}), 32'(0));
        chk("rst_valid", 32'({bus.ad_valid, bus.b_valid, bus.b_propagate}), 32'(0));
        tick();
        reset = 1'b1;
        tick();

        // compute stream, thread 2; base changes after the grant edge must be ignored
        bus.A_addr[2] = 16'h0100;
        bus.D_addr[2] = 16'h0200;
        bus.C_addr[2] = 16'h0300;
        bus.comp_req  = 4'b0100;
        tick();
        bus.A_addr[2] = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            bus.comp_req = cv[i].req;
            @(negedge clock);
            chk("k_read_en",  32'(bus.comp_read_en),         32'(cv[i].en));
            chk("k_a_lane0",  32'(bus.A_row_read_addrs[0]),  32'(cv[i].a0));
            chk("k_a_lane1",  32'(bus.A_row_read_addrs[1]),  32'(cv[i].a1));
            chk("k_d_lane0",  32'(bus.D_col_read_addrs[0]),  32'(cv[i].d0));
            chk("k_ad_valid", 32'(bus.ad_valid),             32'(cv[i].adv));
            chk("k_c_we",     32'(bus.C_write_en),           32'(cv[i].cwe));
            chk("k_c_lane0",  32'(bus.C_col_write_addrs[0]), 32'(cv[i].c0));
            chk("k_c_lane1",  32'(bus.C_col_write_addrs[1]), 32'(cv[i].c1));
            chk("k_done",     32'(bus.comp_done),            32'(cv[i].done));
            chk("k_grant",    32'(bus.comp_grant),           32'(cv[i].grant));
            tick();
        end

        // load stream, thread 1, bank 0
        bus.B_addr[1] = 16'h0040;
        bus.load_req  = 4'b0010;
        tick();
        bus.load_req = '0;
        for (int l = 0; l < 8; l++) begin
            @(negedge clock);
            v0 = (l >= 1 && l < 5);
            v1 = (l >= 2 && l < 6);
            chk("l_read_en", 32'(bus.load_read_en), 32'({(l >= 1 && l < 5), (l < 4)}));
            chk("l_b_lane0", 32'(bus.B_col_read_addrs[0]), (l < 4) ? 32'(16'h40 + 4 * l) : 32'(0));
            chk("l_b_lane1", 32'(bus.B_col_read_addrs[1]),
                (l >= 1 && l < 5) ? 32'(16'h40 + 4 * (l - 1) + 2) : 32'(0));
            chk("l_b_valid", 32'(bus.b_valid), 32'({v1, v0}));
            chk("l_shelf0", 32'(bus.b_shelf_life[0]), v0 ? 32'(5 - l) : 32'(0));
            chk("l_shelf1", 32'(bus.b_shelf_life[1]), v1 ? 32'(6 - l) : 32'(0));
            chk("l_prop", 32'(bus.b_propagate), 32'(0));
            chk("l_done", 32'(bus.load_done), (l == 6) ? 32'(4'b0010) : 32'(0));
            chk("l_grant", 32'(bus.load_grant), (l <= 6) ? 32'(4'b0010) : 32'(0));
            tick();
        end

        // second load runs on the other bank
        bus.load_req = 4'b0010;
        tick();
        bus.load_req = '0;
        tick();
        @(negedge clock);
        chk("l2_b_valid0", 32'(bus.b_valid[0]), 32'(1));
        chk("l2_prop", 32'(bus.b_propagate), 32'(1));
        wait_idle();

        // all four threads hold comp_req; fresh reset so arbitration starts from thread 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.comp_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            t = 0;
            while (bus.comp_grant == 0 && t < 40) begin
                @(negedge clock);
                t++;
            end
`ifdef SYS_SCHED_RR_EN
            exp_g = 4'(1 << (g % 4));
`else
            exp_g = 4'b0001;
`endif
            chk("arb_grant", 32'(bus.comp_grant), 32'(exp_g));
            if (g == 4) bus.comp_req = '0;
            t = 0;
            while (bus.comp_grant != 0 && t < 40) begin
                @(negedge clock);
                t++;
            end
            chk("arb_release", 32'(bus.comp_grant), 32'(0));
        end
        wait_idle();

        // thread 0 asks for both locks, thread 3 for load
        bus.A_addr[0] = 16'h0500;
        bus.B_addr[3] = 16'h0700;
        bus.comp_req  = 4'b0001;
        bus.load_req  = 4'b1001;
        tick();
        @(negedge clock);
        chk("both_comp_grant", 32'(bus.comp_grant), 32'(4'b0001));
        chk("both_load_grant", 32'(bus.load_grant), 32'(4'b1000));

        // reset in the k=3 cycle with requests still held
        repeat (3) tick();
        chk("k3_read_en", 32'(bus.comp_read_en), 32'(2'b11));
        chk("k3_c_we", 32'(bus.C_write_en), 32'(2'b01));
        chk("l3_b_valid", 32'(bus.b_valid), 32'(2'b11));
        reset = 1'b0;
        #1;
        chk("mid_rst_grants", 32'({bus.comp_grant, bus.load_grant}), 32'(0));
        chk("mid_rst_enables", 32'({bus.comp_read_en, bus.C_write_en, bus.load_read_en}), 32'(0));
        chk("mid_rst_valids", 32'({bus.ad_valid, bus.b_valid, bus.b_propagate}), 32'(0));
        chk("mid_rst_a_lane0", 32'(bus.A_row_read_addrs[0]), 32'(0));
        chk("mid_rst_c_lane0", 32'(bus.C_col_write_addrs[0]), 32'(0));
        tick();
        reset = 1'b1;
        tick();
        @(negedge clock);
        chk("rearb_comp_grant", 32'(bus.comp_grant), 32'(4'b0001));
        chk("rearb_load_grant", 32'(bus.load_grant), 32'(4'b1000));
        chk("rearb_read_en", 32'(bus.comp_read_en), 32'(2'b01));
        chk("rearb_a_lane0", 32'(bus.A_row_read_addrs[0]), 32'(16'h0500));
        chk("rearb_b_lane0", 32'(bus.B_col_read_addrs[0]), 32'(16'h0700));
        bus.comp_req = '0;
        bus.load_req = '0;
        wait_idle();

        // address wrap
        bus.A_addr[0] = 16'hFFFE;
        bus.comp_req  = 4'b0001;
        tick();
        bus.comp_req = '0;
        @(negedge clock);
        chk("wrap_k0_lane0", 32'(bus.A_row_read_addrs[0]), 32'(16'hFFFE));
        tick();
        @(negedge clock);
        chk("wrap_k1_lane0", 32'(bus.A_row_read_addrs[0]), 32'(16'h0002));
        chk("wrap_k1_lane1", 32'(bus.A_row_read_addrs[1]), 32'(16'h0000));
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sys_array_scheduler.md
# sys_array_scheduler

NTHREADS-way lock arbiter and address sequencer for the systolic array.
- Grants the compute lock (A/D read, C write) and the load lock (B read) to at most one thread each; never both to the same thread.
- Generates per-lane memory addresses, input-valid, shelf-life and propagate signals for the tile.
- Sits between the thread front-ends and `sys_array` / tile memories, replacing the fixed two-thread controller with a parametrised, fair, double-buffer-aware scheduler.

## Interface
- ADDRWIDTH, 16, memory address width
- MESHUNITS, 4, mesh rows/cols (MU)
- TILEUNITS, 4, tile rows/cols (TU); L = MU*TU is the row stride and stream length
- NTHREADS, 4, number of requesting threads (≥2)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- comp_req  in  NTHREADS  compute-lock request, level, held until granted
- A_addr, D_addr, C_addr  in  NTHREADS×ADDRWIDTH  per-thread base addresses
- comp_grant  out  NTHREADS  one-hot or zero compute-lock owner
- comp_done  out  NTHREADS  one-cycle pulse on owner bit at compute completion
- load_req  in  NTHREADS  load-lock request, level
- B_addr  in  NTHREADS×ADDRWIDTH  per-thread B base
- load_grant  out  NTHREADS  one-hot or zero load-lock owner
- load_done  out  NTHREADS  one-cycle pulse at load completion
- A_row_read_addrs, D_col_read_addrs  out  MU×ADDRWIDTH  per-lane read address
- comp_read_en  out  MU  per-lane A/D read strobe
- ad_valid  out  MU  A/D valid to array (comp_read_en delayed 1)
- C_col_write_addrs  out  MU×ADDRWIDTH, C_write_en  out  MU  C write stream
- B_col_read_addrs  out  MU×ADDRWIDTH, load_read_en  out  MU  B read stream
- b_valid  out  MU, b_shelf_life  out  MU×($clog2(L)+1), b_propagate  out  1  B controls to array

## Operation
- Base addresses are sampled on the grant edge. Compute counter k and load counter l start at 0 the cycle after the grant and increment every cycle while the lock is held.
- Compute lane i, active when i ≤ k < L+i:
  - comp_read_en[i]=1
  - A/D addr = base + (k−i)·L + i·TU
- Compute write lane i, active when MU+1+i ≤ k < MU+1+i+L:
  - C_write_en[i]=1
  - C addr = C_base + (k−MU−1−i)·L + i·TU
- comp_done is asserted while k = MU·(2+TU).
- Load lane i, active when i ≤ l < L+i:
  - load_read_en[i]=1
  - B addr = B_base + (l−i)·L + i·TU
- b_valid[i] is load_read_en[i] delayed 1.
  - b_shelf_life[i] = L−(l−1−i) when valid, else 0.
  - b_propagate = bank bit when any b_valid, else 0.
  - The bank bit toggles on every load_done, giving double-buffer ping-pong.
- load_done is asserted while l = MU·(1+TU).
- Inactive lanes and unlocked streams drive address, enable and valid outputs to 0.
- Arithmetic is modulo 2^ADDRWIDTH; wrap is silent. Counters are $clog2(MU·(2+TU)+1) bits and never exceed their end value.
- Arbitration is evaluated on each edge where a lock is free:
  - Compute is arbitrated first.
  - Load excludes the thread holding or just granted compute.
  - If one thread requests both with both locks free, it gets compute; load goes to the next eligible requester.
  - Dropping a request after grant has no effect; the done pulse still fires.

## Timing
- Grant latency: 1 edge after request while the lock is free.
- Lock release happens on the edge where done is high. The earliest re-grant of that lock is the following edge, leaving one idle cycle.
- Read-to-valid latency: 1 cycle. Read-to-C-write latency: MU+1 cycles.
- A compute occupies MU·(2+TU)+1 cycles from grant; a load occupies MU·(1+TU)+1 cycles.
- Compute and load run concurrently and independently. A simultaneous comp_done and load grant are legal.
- Reset asserted mid-operation, effective immediately:
  - grants, done, all address/enable/valid outputs, counters, bank bit and arbitration pointer go to 0.
  - After release, requests still held are re-arbitrated from scratch.

## Configuration
- SYS_SCHED_RR_EN defined: both locks use round-robin. The search starts at the thread after the last grantee; each lock has its own pointer.
- Not defined: fixed priority, lowest index wins. No pointer registers are built.

## Test plan
Settings: MU=2, TU=2 (L=4), NTHREADS=4, ADDRWIDTH=16.
- Thread 2 comp_req, A_addr=0x100:
  - k=0: lane0 reads 0x100, lane1 off.
  - k=1: lane0 0x104, lane1 0x102; ad_valid[0] high.
  - C_write_en[0] at k=3..6.
  - comp_done[2] at k=8, grant drops the next edge.
- Thread 1 load, B_addr=0x40:
  - b_valid[0] at l=1..4 with shelf life 4,3,2,1.
  - load_done[1] at l=6.
  - b_propagate=0; a second load shows b_propagate=1.
- Threads 0–3 all request comp continuously:
  - RR_EN: grant order 0,1,2,3,0.
  - Without RR_EN: 0 every time.
- Thread 0 requests comp+load, thread 3 requests load, both locks free: comp_grant=0001, load_grant=1000 on the same edge.
- reset low at k=3:
  - all outputs are 0 before the next edge.
  - After release with comp_req held, re-granted and streams restart at k=0.
- A_addr=0xFFFE: lane0 reads 0xFFFE, then 0x0002 at k=1 (wrap).
